// File: rtl/router_alloc_pkg.sv
// rtl/router_alloc_pkg.sv - shared types and helpers for the router allocation stages
package router_alloc_pkg;

    typedef enum logic [0:0] {
        ALLOC_IDLE   = 1'b0,
        ALLOC_LOCKED = 1'b1
    } alloc_state_e;

    localparam int RR_MAX   = 32;
    localparam int RR_IDX_W = 5;

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // First set bit of mask searching upward from ptr+1, wrapping at n.
    function automatic logic [RR_MAX-1:0] rr_next(
        input logic [RR_MAX-1:0]   mask,
        input logic [RR_IDX_W-1:0] ptr,
        input int                  n
    );
        logic [RR_MAX-1:0]   pick;
        logic                found;
        int                  idx;
        logic [RR_IDX_W-1:0] sel;
        pick  = '0;
        found = 1'b0;
        for (int k = 1; k <= RR_MAX; k++) begin
            idx = (int'(ptr) + k) % n;
            sel = idx[RR_IDX_W-1:0];
            if (k <= n && !found && mask[sel]) begin
                pick[sel] = 1'b1;
                found     = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin picker
module rr_arbiter
    import router_alloc_pkg::*;
#(
    parameter int N  = 5,
    parameter int PW = idx_width(N)
) (
    input  logic [N-1:0]  mask,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic          any_valid
);

    logic [RR_MAX-1:0] pick;

    assign pick      = rr_next(RR_MAX'(mask), RR_IDX_W'(ptr), N);
    assign grant     = pick[N-1:0];
    assign any_valid = |pick;

endmodule

// File: rtl/router_output_allocator.sv
// rtl/router_output_allocator.sv - per-output wormhole switch allocator with credit gating
module router_output_allocator
    import router_alloc_pkg::*;
#(
    parameter int NUM_INPUTS   = 5,
    parameter int CREDIT_DEPTH = 2,
    parameter int CNT_WIDTH    = $clog2(CREDIT_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_INPUTS-1:0] req,
    input  logic [NUM_INPUTS-1:0] req_is_tail,
    input  logic [NUM_INPUTS-1:0] turn_disable,
    input  logic                  credit_in,
    output logic                  grant_valid,
    output logic [NUM_INPUTS-1:0] grant,
    output logic [NUM_INPUTS-1:0] pop,
    output logic                  send,
    output logic [CNT_WIDTH-1:0]  credit_count,
    output logic                  credit_overflow
);

    localparam int PTR_W = idx_width(NUM_INPUTS);
    localparam logic [CNT_WIDTH-1:0] CREDIT_MAX = CNT_WIDTH'(CREDIT_DEPTH);

    alloc_state_e          state;
    logic [NUM_INPUTS-1:0] owner;
    logic [PTR_W-1:0]      rr_ptr;
    logic [PTR_W-1:0]      owner_idx;
    logic [NUM_INPUTS-1:0] eligible;
    logic [NUM_INPUTS-1:0] pick;
    logic                  pick_valid;
    logic                  tail_pop;

    assign eligible = req & ~turn_disable;

    rr_arbiter #(
        .N  (NUM_INPUTS),
        .PW (PTR_W)
    ) u_rr_arbiter (
        .mask      (eligible),
        .ptr       (rr_ptr),
        .grant     (pick),
        .any_valid (pick_valid)
    );

    // Only the locked owner may dequeue, and only when a downstream slot exists.
    always_comb begin
        pop = '0;
        if (state == ALLOC_LOCKED && credit_count != '0) begin
            pop = owner & req;
        end
    end

    assign send        = |pop;
    assign tail_pop    = |(pop & req_is_tail);
    assign grant_valid = (state == ALLOC_LOCKED);
    assign grant       = owner;

    always_comb begin
        owner_idx = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (owner[i]) begin
                owner_idx = PTR_W'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ALLOC_IDLE;
            owner  <= '0;
            rr_ptr <= PTR_W'(NUM_INPUTS - 1);
        end else begin
            case (state)
                ALLOC_IDLE: begin
                    if (pick_valid) begin
                        owner <= pick;
                        state <= ALLOC_LOCKED;
                    end
                end
                ALLOC_LOCKED: begin
                    if (tail_pop) begin
                        owner  <= '0;
                        rr_ptr <= owner_idx;
                        state  <= ALLOC_IDLE;
                    end
                end
                default: begin
                    owner <= '0;
                    state <= ALLOC_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credit_count    <= CREDIT_MAX;
            credit_overflow <= 1'b0;
        end else begin
            case ({send, credit_in})
                2'b10: credit_count <= credit_count - 1'b1;
                2'b01: begin
                    if (credit_count == CREDIT_MAX) begin
                        credit_overflow <= 1'b1;
                    end else begin
                        credit_count <= credit_count + 1'b1;
                    end
                end
                default: credit_count <= credit_count;
            endcase
        end
    end

endmodule

// File: tb/tb_router_output_allocator.sv
// tb/tb_router_output_allocator.sv - directed table-driven bench for router_output_allocator
module tb_router_output_allocator;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] req = '0;
    logic [4:0] req_is_tail = '0;
    logic [4:0] turn_disable = '0;
    logic       credit_in = 1'b0;
    logic       grant_valid;
    logic [4:0] grant;
    logic [4:0] pop;
    logic       send;
    logic [1:0] credit_count;
    logic       credit_overflow;

    int n_tests = 0;
    int n_fail  = 0;

    router_output_allocator #(
        .NUM_INPUTS   (5),
        .CREDIT_DEPTH (2)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req             (req),
        .req_is_tail     (req_is_tail),
        .turn_disable    (turn_disable),
        .credit_in       (credit_in),
        .grant_valid     (grant_valid),
        .grant           (grant),
        .pop             (pop),
        .send            (send),
        .credit_count    (credit_count),
        .credit_overflow (credit_overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [4:0] req;
        logic [4:0] tail;
        logic [4:0] td;
        logic       cin;
        logic       gv;
        logic [4:0] grant;
        logic [4:0] pop;
        logic [1:0] cc;
        logic       ov;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic [4:0] rq, input logic [4:0] tl,
                       input logic [4:0] td, input logic cin, input logic gv,
                       input logic [4:0] gr, input logic [4:0] pp,
                       input logic [1:0] cc, input logic ov);
        vec_t v;
        v.rst = rst; v.req = rq; v.tail = tl; v.td = td; v.cin = cin;
        v.gv = gv; v.grant = gr; v.pop = pp; v.cc = cc; v.ov = ov;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag, input logic gv, input logic [4:0] gr,
                                 input logic [4:0] pp, input logic [1:0] cc, input logic ov);
        chk({tag, ".grant_valid"}, 32'(grant_valid), 32'(gv));
        chk({tag, ".grant"}, 32'(grant), 32'(gr));
        chk({tag, ".pop"}, 32'(pop), 32'(pp));
        chk({tag, ".send"}, 32'(send), 32'(|pp));
        chk({tag, ".credit_count"}, 32'(credit_count), 32'(cc));
        chk({tag, ".credit_overflow"}, 32'(credit_overflow), 32'(ov));
    endtask

    initial begin
        // single flit from input 2
        add(1, 5'b00000, 5'b00000, 5'b00000, 0, 0, 5'b00000, 5'b00000, 2, 0);
        add(0, 5'b00100, 5'b00100, 5'b00000, 0, 0, 5'b00000, 5'b00000, 2, 0);
        add(0, 5'b00100, 5'b00100, 5'b00000, 0, 1, 5'b00100, 5'b00100, 2, 0);
        add(0, 5'b00000, 5'b00000, 5'b00000, 1, 0, 5'b00000, 5'b00000, 1, 0);
        // round-robin over all five inputs, credit returned on every pop
        for (int p = 0; p < 6; p++) begin
            add(p == 0, 5'b11111, 5'b11111, 5'b00000, 0, 0, 5'b00000, 5'b00000, 2, 0);
            add(0, 5'b11111, 5'b11111, 5'b00000, 1, 1, 5'(1 << (p % 5)), 5'(1 << (p % 5)), 2, 0);
        end
        // 4-flit packet from input 1 starved of credits, input 3 waiting
        add(1, 5'b01010, 5'b00000, 5'b00000, 0, 0, 5'b00000, 5'b00000, 2, 0);
        add(0, 5'b01010, 5'b00000, 5'b00000, 0, 1, 5'b00010, 5'b00010, 2, 0);
        add(0, 5'b01010, 5'b00000, 5'b00000, 0, 1, 5'b00010, 5'b00010, 1, 0);
        add(0, 5'b01010, 5'b00000, 5'b00000, 0, 1, 5'b00010, 5'b00000, 0, 0);
        add(0, 5'b01010, 5'b00000, 5'b00000, 1, 1, 5'b00010, 5'b00000, 0, 0);
        add(0, 5'b01010, 5'b00000, 5'b00000, 0, 1, 5'b00010, 5'b00010, 1, 0);
        add(0, 5'b01010, 5'b00000, 5'b00000, 0, 1, 5'b00010, 5'b00000, 0, 0);
        add(0, 5'b01010, 5'b00000, 5'b00000, 1, 1, 5'b00010, 5'b00000, 0, 0);
        add(0, 5'b01010, 5'b00010, 5'b00000, 0, 1, 5'b00010, 5'b00010, 1, 0);
        add(0, 5'b01000, 5'b01000, 5'b00000, 1, 0, 5'b00000, 5'b00000, 0, 0);
        add(0, 5'b01000, 5'b01000, 5'b00000, 0, 1, 5'b01000, 5'b01000, 1, 0);
        add(0, 5'b00000, 5'b00000, 5'b00000, 1, 0, 5'b00000, 5'b00000, 0, 0);
        add(0, 5'b00000, 5'b00000, 5'b00000, 1, 0, 5'b00000, 5'b00000, 1, 0);
        // turn_disable blocks allocation only
        add(0, 5'b00010, 5'b00000, 5'b00010, 0, 0, 5'b00000, 5'b00000, 2, 0);
        add(0, 5'b00010, 5'b00000, 5'b00010, 0, 0, 5'b00000, 5'b00000, 2, 0);
        add(0, 5'b00010, 5'b00000, 5'b00000, 0, 0, 5'b00000, 5'b00000, 2, 0);
        add(0, 5'b00010, 5'b00000, 5'b00010, 0, 1, 5'b00010, 5'b00010, 2, 0);
        add(0, 5'b00010, 5'b00010, 5'b00010, 1, 1, 5'b00010, 5'b00010, 1, 0);
        add(0, 5'b00000, 5'b00000, 5'b00000, 1, 0, 5'b00000, 5'b00000, 1, 0);
        // overflow at full count, then send with credit_in at count 1
        add(0, 5'b00000, 5'b00000, 5'b00000, 1, 0, 5'b00000, 5'b00000, 2, 0);
        add(0, 5'b00000, 5'b00000, 5'b00000, 0, 0, 5'b00000, 5'b00000, 2, 1);
        add(0, 5'b00001, 5'b00001, 5'b00000, 0, 0, 5'b00000, 5'b00000, 2, 1);
        add(0, 5'b00001, 5'b00001, 5'b00000, 0, 1, 5'b00001, 5'b00001, 2, 1);
        add(0, 5'b00001, 5'b00001, 5'b00000, 0, 0, 5'b00000, 5'b00000, 1, 1);
        add(0, 5'b00001, 5'b00001, 5'b00000, 1, 1, 5'b00001, 5'b00001, 1, 1);
        add(0, 5'b00000, 5'b00000, 5'b00000, 0, 0, 5'b00000, 5'b00000, 1, 1);

        @(posedge clk);
        #1;
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rst) begin
                rst_n = 1'b0;
                #2;
                rst_n = 1'b1;
            end
            req          = vecs[i].req;
            req_is_tail  = vecs[i].tail;
            turn_disable = vecs[i].td;
            credit_in    = vecs[i].cin;
            @(negedge clk);
            check_outputs($sformatf("vec%0d", i), vecs[i].gv, vecs[i].grant,
                          vecs[i].pop, vecs[i].cc, vecs[i].ov);
            @(posedge clk);
            #1;
        end

        // asynchronous reset while locked with zero credits
        rst_n = 1'b0;
        #2;
        rst_n        = 1'b1;
        req          = 5'b00100;
        req_is_tail  = 5'b00000;
        turn_disable = 5'b00000;
        credit_in    = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check_outputs("stall", 1'b1, 5'b00100, 5'b00000, 2'd0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_outputs("async_rst", 1'b0, 5'b00000, 5'b00000, 2'd2, 1'b0);
        #1;
        rst_n       = 1'b1;
        req         = 5'b10001;
        req_is_tail = 5'b10001;
        @(posedge clk);
        #1;
        check_outputs("post_rst", 1'b1, 5'b00001, 5'b00001, 2'd2, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
